regfile_wb_ctrl: RTL and testbench
==================================

// Module: regfile_wb_ctrl
// PURPOSE
// - Shares the register file's single write port (rd/wen/dataD) between NUM_REQ writeback producers.
//   Producers are ALU, LSU and CSR. Arbitration is round-robin.
// - Holds a per-register pending-write scoreboard. Issue reads it to stall RAW/WAW hazards.
// - Sits between the execute/memory writeback paths and register_file. It drives the write port directly.
// PARAMETERS
// - ADDR_WIDTH  5   register index width; scoreboard has 1<<ADDR_WIDTH bits
// - DATA_WIDTH  64  writeback data width
// - NUM_REQ     3   number of writeback requesters; must be >= 2
// PORTS
// - clk            in   1                     single clock; all state updates on posedge
// - rst_n          in   1                     asynchronous, active-low reset
// - req_valid      in   NUM_REQ               producer i has a writeback pending
// - req_ready      out  NUM_REQ               one-hot grant; handshake when valid[i] && ready[i]
// - req_rd         in   NUM_REQ*ADDR_WIDTH    packed dest index; slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]
// - req_data       in   NUM_REQ*DATA_WIDTH    packed writeback data, same packing
// - rf_wen         out  1                     register file write enable
// - rf_rd          out  ADDR_WIDTH            register file write index
// - rf_data        out  DATA_WIDTH            register file write data
// - rsv_valid      in   1                     issue reserves a destination register
// - rsv_rd         in   ADDR_WIDTH            register being reserved
// - rsv_ready      out  1                     reservation accepted (combinational)
// - rs1, rs2       in   ADDR_WIDTH            source indices for hazard query
// - rs1_busy       out  1                     busy[rs1] (combinational)
// - rs2_busy       out  1                     busy[rs2] (combinational)
// - wb_err         out  1                     sticky: writeback to a non-busy nonzero register
// BEHAVIOUR
// - Reset (async, rst_n=0): busy all 0, rf_wen=0, rf_rd=0, rf_data=0, wb_err=0, rr_ptr=0 (req0 top priority).
//   An in-flight write is dropped; no rf write happens during reset.
// - Arbitration is combinational. Priority order starts at rr_ptr. At most one req_ready is high.
//   req_ready[i]=0 whenever req_valid[i]=0.
// - On a handshake with index g, rr_ptr <= (g+1) mod NUM_REQ. With no handshake, rr_ptr holds.
// - Producers hold valid/rd/data stable until ready. Dropping valid without a handshake is allowed.
// - Latency is 1. A handshake in cycle N gives rf_wen=1, rf_rd, rf_data registered in cycle N+1.
//   The rf write lands at the edge ending N+1. The rf port never stalls, so no backpressure reaches the output reg.
// - rf_wen=0 in any cycle that follows no handshake. rf_rd/rf_data hold their last value.
// - A handshake with rd==0 is accepted: req_ready high, rf_wen stays 0, scoreboard untouched.
// - Scoreboard clear: busy[rf_rd] <= 0 on the edge where rf_wen=1 (the same edge the data lands).
//   rs*_busy therefore goes low in the same cycle the rf read returns the new value.
// - Reservation: rsv_ready = (rsv_rd==0) || !busy[rsv_rd]. On rsv_valid && rsv_ready && rsv_rd!=0, busy[rsv_rd] <= 1.
//   A reservation of x0 is always accepted and has no effect.
// - Set and clear of the same register on the same edge: set wins, so the register stays busy for the new writer.
// - busy[0] is constant 0, so rs*_busy=0 for x0.
// - wb_err <= 1 on a handshake with rd!=0 && !busy[rd]. It clears only on reset. The write still proceeds.
// - Simultaneous handshake and reservation: both are legal in one cycle and update independently.
// STRUCTURE
// - Shared package regfile_pkg holds:
//   - REG_ADDR_W=5 and XLEN=64 defaults;
//   - requester IDs WB_ALU=0, WB_LSU=1, WB_CSR=2;
//   - the packing helper macro for req_rd/req_data slices.
// - One sub-module: rr_arbiter #(N) with ports req[N], ptr, gnt[N] onehot, gnt_idx.
//   It is purely combinational; the rr_ptr flop lives in regfile_wb_ctrl.
// - regfile_wb_ctrl owns the output register, the busy vector, rr_ptr and wb_err.
// TESTING
// - Reset: after rst_n low then high, all outputs are 0, busy=0.
//   Reserve x5, then wait. Then writeback req1 rd=5 data=0xAB.
//   Expect rf_wen=1, rf_rd=5, rf_data=0xAB exactly 1 cycle after the handshake, and rs1_busy(5)=0 the next cycle.
// - Round-robin: all 3 valid continuously, rr_ptr=0. Grants are 0,1,2,0,1,2.
//   Drop valid[1] and the sequence becomes 0,2,0,2. No cycle ever has two ready bits high.
// - x0 handling: reserve x0 gives rsv_ready=1 and busy unchanged. Writeback rd=0 data=0xFF gives ready=1, rf_wen=0, wb_err=0.
// - Hazard: reserve x7 gives rs2_busy(7)=1. A second reserve of x7 gives rsv_ready=0.
//   Writeback x7 and reserve x7 again in the rf_wen cycle: rsv_ready=0 that cycle, rsv_ready=1 the cycle after.
// - Error: writeback rd=9 with busy[9]=0 gives wb_err=1 from the next cycle, and the write is still performed.
//   wb_err stays 1 until reset.
// - Reset mid-op: assert rst_n=0 the cycle after a handshake. rf_wen drops to 0 asynchronously, busy clears, no write lands.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file definitions: default widths, writeback requester IDs and
// the slice helper for the packed per-requester buses.
`ifndef REGFILE_PKG_SV
`define REGFILE_PKG_SV

// Slice idx of a bus packed as NUM_REQ fields of width w, field 0 in the LSBs.
`define RF_SLICE(idx, w) ((idx)*(w)) +: (w)

package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 64;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_LSU = 2'd1,
    WB_CSR = 2'd2
  } wb_src_e;

endpackage

`endif

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps, so the
// first asserted request at or after ptr wins. The pointer flop lives in the parent.
module rr_arbiter #(
  parameter int N = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  int            j;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      idx = PW'(j);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: arbitrates NUM_REQ producers onto the single register-file
// write port and keeps the per-register pending-write (busy) scoreboard used by issue.
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int DATA_WIDTH = XLEN,
  parameter int NUM_REQ    = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_rd,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic                             rf_wen,
  output logic [ADDR_WIDTH-1:0]            rf_rd,
  output logic [DATA_WIDTH-1:0]            rf_data,
  input  logic                             rsv_valid,
  input  logic [ADDR_WIDTH-1:0]            rsv_rd,
  output logic                             rsv_ready,
  input  logic [ADDR_WIDTH-1:0]            rs1,
  input  logic [ADDR_WIDTH-1:0]            rs2,
  output logic                             rs1_busy,
  output logic                             rs2_busy,
  output logic                             wb_err
);

  localparam int NREG = 1 << ADDR_WIDTH;
  localparam int PW   = $clog2(NUM_REQ);

  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         rr_nxt;
  logic [PW-1:0]         gnt_idx;
  logic [NUM_REQ-1:0]    gnt;
  logic                  hs;
  logic [ADDR_WIDTH-1:0] g_rd;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  wr_en;
  logic                  rsv_fire;
  logic [NREG-1:0]       busy;
  logic [NREG-1:0]       busy_nxt;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Handshake: a transfer happens on a rising edge where req_valid[i] && req_ready[i];
  // ready is only ever raised for a valid requester, and at most one at a time.
  assign req_ready = gnt;
  assign hs        = |gnt;

  always_comb begin
    g_rd   = '0;
    g_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        g_rd   = req_rd[`RF_SLICE(i, ADDR_WIDTH)];
        g_data = req_data[`RF_SLICE(i, DATA_WIDTH)];
      end
    end
  end

  // x0 writebacks are acknowledged but never reach the register file.
  assign wr_en     = hs && (g_rd != '0);
  assign rsv_ready = (rsv_rd == '0) || !busy[rsv_rd];
  assign rsv_fire  = rsv_valid && rsv_ready && (rsv_rd != '0);
  assign rs1_busy  = busy[rs1];
  assign rs2_busy  = busy[rs2];
  assign rr_nxt    = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Clear is applied before set so a new reservation survives the landing write.
  always_comb begin
    busy_nxt = busy;
    if (rf_wen) busy_nxt[rf_rd] = 1'b0;
    if (rsv_fire) busy_nxt[rsv_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen  <= 1'b0;
      rf_rd   <= '0;
      rf_data <= '0;
      busy    <= '0;
      rr_ptr  <= '0;
      wb_err  <= 1'b0;
    end else begin
      rf_wen <= wr_en;
      if (wr_en) begin
        rf_rd   <= g_rd;
        rf_data <= g_data;
      end
      busy <= busy_nxt;
      if (hs) rr_ptr <= rr_nxt;
      if (wr_en && !busy[g_rd]) wb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed, table-driven bench for regfile_wb_ctrl: one vector per clock cycle,
// plus a hand-written asynchronous-reset-during-writeback sequence.
module tb_regfile_wb_ctrl;
  import regfile_pkg::*;

  localparam int AW = 5;
  localparam int DW = 64;
  localparam int NR = 3;
  localparam int NV = 28;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*AW-1:0]  req_rd = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic              rf_wen;
  logic [AW-1:0]     rf_rd;
  logic [DW-1:0]     rf_data;
  logic              rsv_valid = 1'b0;
  logic [AW-1:0]     rsv_rd = '0;
  logic              rsv_ready;
  logic [AW-1:0]     rs1 = '0;
  logic [AW-1:0]     rs2 = '0;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              wb_err;

  regfile_wb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .rf_wen    (rf_wen),
    .rf_rd     (rf_rd),
    .rf_data   (rf_data),
    .rsv_valid (rsv_valid),
    .rsv_rd    (rsv_rd),
    .rsv_ready (rsv_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .wb_err    (wb_err)
  );

  // ---------------- clock / reset
  always #5 clk = ~clk;

  // ---------------- vector table
  typedef struct {
    logic [2:0]  valid;
    logic [4:0]  rd0, rd1, rd2;
    logic [15:0] d0, d1, d2;
    logic        rsv_v;
    logic [4:0]  rsv_rd, rs1, rs2;
    logic [2:0]  e_ready;
    logic        e_rsv, e_b1, e_b2, e_wen;
    logic [4:0]  e_rd;
    logic [15:0] e_data;
    logic        e_err;
    logic        cmp_rf;
  } vec_t;

  vec_t vec [NV];

  function automatic vec_t mk(
    logic [2:0] valid, logic [4:0] rd0, logic [4:0] rd1, logic [4:0] rd2,
    logic [15:0] d0, logic [15:0] d1, logic [15:0] d2,
    logic rsv_v, logic [4:0] rsv_rd_i, logic [4:0] rs1_i, logic [4:0] rs2_i,
    logic [2:0] e_ready, logic e_rsv, logic e_b1, logic e_b2, logic e_wen,
    logic [4:0] e_rd, logic [15:0] e_data, logic e_err, logic cmp_rf);
    vec_t v;
    v.valid = valid; v.rd0 = rd0; v.rd1 = rd1; v.rd2 = rd2;
    v.d0 = d0; v.d1 = d1; v.d2 = d2;
    v.rsv_v = rsv_v; v.rsv_rd = rsv_rd_i; v.rs1 = rs1_i; v.rs2 = rs2_i;
    v.e_ready = e_ready; v.e_rsv = e_rsv; v.e_b1 = e_b1; v.e_b2 = e_b2;
    v.e_wen = e_wen; v.e_rd = e_rd; v.e_data = e_data; v.e_err = e_err;
    v.cmp_rf = cmp_rf;
    return v;
  endfunction

  // ---------------- scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [AW+DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- drivers
  task automatic drive_vec(input vec_t v);
    req_valid = v.valid;
    req_rd    = {v.rd2, v.rd1, v.rd0};
    req_data  = {64'(v.d2), 64'(v.d1), 64'(v.d0)};
    rsv_valid = v.rsv_v;
    rsv_rd    = v.rsv_rd;
    rs1       = v.rs1;
    rs2       = v.rs2;
  endtask

  task automatic drive_idle();
    req_valid = '0;
    rsv_valid = 1'b0;
  endtask

  initial begin
    logic [AW+DW-1:0] e;
    //                 valid  rd0 rd1 rd2 d0      d1      d2      rv rrd rs1 rs2   ready   rsv b1 b2 wen rd  data     err cmp
    // reset state, reserve x5, write x5 through req1 (LSU)
    vec[0]  = mk(3'b000, 0, 0, 0, 16'h0,  16'h0,  16'h0,  0, 5, 5, 31,  3'b000, 1, 0, 0, 0, 0,  16'h0,   0, 1);
    vec[1]  = mk(3'b000, 0, 0, 0, 16'h0,  16'h0,  16'h0,  1, 5, 5, 0,   3'b000, 1, 0, 0, 0, 0,  16'h0,   0, 1);
    vec[2]  = mk(3'b000, 0, 0, 0, 16'h0,  16'h0,  16'h0,  0, 5, 5, 0,   3'b000, 0, 1, 0, 0, 0,  16'h0,   0, 1);
    vec[3]  = mk(3'b010, 0, 5, 0, 16'h0,  16'hAB, 16'h0,  0, 0, 5, 0,   3'b010, 1, 1, 0, 0, 0,  16'h0,   0, 1);
    vec[4]  = mk(3'b000, 0, 0, 0, 16'h0,  16'h0,  16'h0,  0, 0, 5, 0,   3'b000, 1, 1, 0, 1, 5,  16'hAB,  0, 1);
    // x0 reservation, then x0 writeback
    vec[5]  = mk(3'b000, 0, 0, 0, 16'h0,  16'h0,  16'h0,  1, 0, 5, 0,   3'b000, 1, 0, 0, 0, 5,  16'hAB,  0, 1);
    vec[6]  = mk(3'b001, 0, 0, 0, 16'hFF, 16'h0,  16'h0,  0, 0, 0, 0,   3'b001, 1, 0, 0, 0, 5,  16'hAB,  0, 1);
    vec[7]  = mk(3'b000, 0, 0, 0, 16'h0,  16'h0,  16'h0,  0, 0, 0, 0,   3'b000, 1, 0, 0, 0, 0,  16'h0,   0, 0);
    // x7 hazard: double reserve, writeback, re-reserve during and after the write
    vec[8]  = mk(3'b000, 0, 0, 0, 16'h0,  16'h0,  16'h0,  1, 7, 0, 7,   3'b000, 1, 0, 0, 0, 0,  16'h0,   0, 0);
    vec[9]  = mk(3'b000, 0, 0, 0, 16'h0,  16'h0,  16'h0,  1, 7, 0, 7,   3'b000, 0, 0, 1, 0, 0,  16'h0,   0, 0);
    vec[10] = mk(3'b100, 0, 0, 7, 16'h0,  16'h0,  16'h77, 0, 7, 0, 7,   3'b100, 0, 0, 1, 0, 0,  16'h0,   0, 0);
    vec[11] = mk(3'b000, 0, 0, 0, 16'h0,  16'h0,  16'h0,  1, 7, 0, 7,   3'b000, 0, 0, 1, 1, 7,  16'h77,  0, 1);
    vec[12] = mk(3'b000, 0, 0, 0, 16'h0,  16'h0,  16'h0,  1, 7, 0, 7,   3'b000, 1, 0, 0, 0, 7,  16'h77,  0, 1);
    // write to non-busy x9 sets wb_err; reserve x9 on its landing edge (set wins)
    vec[13] = mk(3'b010, 0, 9, 0, 16'h0,  16'h99, 16'h0,  0, 0, 9, 7,   3'b010, 1, 0, 1, 0, 7,  16'h77,  0, 1);
    vec[14] = mk(3'b000, 0, 0, 0, 16'h0,  16'h0,  16'h0,  1, 9, 9, 7,   3'b000, 1, 0, 1, 1, 9,  16'h99,  1, 1);
    vec[15] = mk(3'b100, 0, 0, 9, 16'h0,  16'h0,  16'h1234, 0, 0, 9, 7, 3'b100, 1, 1, 1, 0, 9,  16'h99,  1, 1);
    // all three valid from rr_ptr=0, then req1 drops out
    vec[16] = mk(3'b111, 10, 11, 12, 16'hA0, 16'hB1, 16'hC2, 0, 0, 9, 7, 3'b001, 1, 1, 1, 1, 9,  16'h1234, 1, 1);
    vec[17] = mk(3'b111, 10, 11, 12, 16'hA0, 16'hB1, 16'hC2, 0, 0, 9, 7, 3'b010, 1, 0, 1, 1, 10, 16'hA0,  1, 1);
    vec[18] = mk(3'b111, 10, 11, 12, 16'hA0, 16'hB1, 16'hC2, 0, 0, 9, 7, 3'b100, 1, 0, 1, 1, 11, 16'hB1,  1, 1);
    vec[19] = mk(3'b111, 10, 11, 12, 16'hA0, 16'hB1, 16'hC2, 0, 0, 9, 7, 3'b001, 1, 0, 1, 1, 12, 16'hC2,  1, 1);
    vec[20] = mk(3'b111, 10, 11, 12, 16'hA0, 16'hB1, 16'hC2, 0, 0, 9, 7, 3'b010, 1, 0, 1, 1, 10, 16'hA0,  1, 1);
    vec[21] = mk(3'b111, 10, 11, 12, 16'hA0, 16'hB1, 16'hC2, 0, 0, 9, 7, 3'b100, 1, 0, 1, 1, 11, 16'hB1,  1, 1);
    vec[22] = mk(3'b101, 10, 11, 12, 16'hA0, 16'hB1, 16'hC2, 0, 0, 9, 7, 3'b001, 1, 0, 1, 1, 12, 16'hC2,  1, 1);
    vec[23] = mk(3'b101, 10, 11, 12, 16'hA0, 16'hB1, 16'hC2, 0, 0, 9, 7, 3'b100, 1, 0, 1, 1, 10, 16'hA0,  1, 1);
    vec[24] = mk(3'b101, 10, 11, 12, 16'hA0, 16'hB1, 16'hC2, 0, 0, 9, 7, 3'b001, 1, 0, 1, 1, 12, 16'hC2,  1, 1);
    vec[25] = mk(3'b101, 10, 11, 12, 16'hA0, 16'hB1, 16'hC2, 0, 0, 9, 7, 3'b100, 1, 0, 1, 1, 10, 16'hA0,  1, 1);
    vec[26] = mk(3'b000, 0, 0, 0, 16'h0,  16'h0,  16'h0,  0, 0, 9, 7,   3'b000, 1, 0, 1, 1, 12, 16'hC2,  1, 1);
    vec[27] = mk(3'b000, 0, 0, 0, 16'h0,  16'h0,  16'h0,  0, 0, 9, 7,   3'b000, 1, 0, 1, 0, 12, 16'hC2,  1, 1);

    // reset
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven cycles
    for (int i = 0; i < NV; i++) begin
      if (i > 0) @(negedge clk);
      drive_vec(vec[i]);
      #1;
      chk($sformatf("v%0d req_ready", i), 64'(req_ready), 64'(vec[i].e_ready));
      chk($sformatf("v%0d ready_onehot", i), 64'($countones(req_ready) <= 1), 64'd1);
      chk($sformatf("v%0d rsv_ready", i), 64'(rsv_ready), 64'(vec[i].e_rsv));
      chk($sformatf("v%0d rs1_busy", i), 64'(rs1_busy), 64'(vec[i].e_b1));
      chk($sformatf("v%0d rs2_busy", i), 64'(rs2_busy), 64'(vec[i].e_b2));
      chk($sformatf("v%0d rf_wen", i), 64'(rf_wen), 64'(vec[i].e_wen));
      chk($sformatf("v%0d wb_err", i), 64'(wb_err), 64'(vec[i].e_err));
      if (vec[i].cmp_rf) begin
        chk($sformatf("v%0d rf_rd", i), 64'(rf_rd), 64'(vec[i].e_rd));
        chk($sformatf("v%0d rf_data", i), rf_data, 64'(vec[i].e_data));
      end
      if (vec[i].e_wen) exp_q.push_back({vec[i].e_rd, 64'(vec[i].e_data)});
      if (rf_wen) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("v%0d rf_write_expected", i), 64'd0, 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("v%0d rf_write_rd", i), 64'(rf_rd), 64'(e[AW+DW-1:DW]));
          chk($sformatf("v%0d rf_write_data", i), rf_data, e[DW-1:0]);
        end
      end
    end
    chk("rf_write_queue_drained", 64'(exp_q.size()), 64'd0);

    // reset in the cycle after a handshake: the pending write must be dropped
    @(negedge clk);
    drive_idle();
    rsv_valid = 1'b1;
    rsv_rd    = 5'd3;
    #1;
    chk("rst_seq rsv_ready x3", 64'(rsv_ready), 64'd1);
    @(negedge clk);
    rsv_valid = 1'b0;
    req_valid = 3'b001;
    req_rd    = {5'd0, 5'd0, 5'd3};
    req_data  = {64'd0, 64'd0, 64'h33};
    rs1       = 5'd3;
    #1;
    chk("rst_seq req_ready", 64'(req_ready), 64'b001);
    chk("rst_seq rs1_busy x3", 64'(rs1_busy), 64'd1);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("rst_seq rf_wen before reset", 64'(rf_wen), 64'd1);
    chk("rst_seq rf_rd before reset", 64'(rf_rd), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("rst_seq rf_wen async", 64'(rf_wen), 64'd0);
    chk("rst_seq rf_rd async", 64'(rf_rd), 64'd0);
    chk("rst_seq rf_data async", rf_data, 64'd0);
    chk("rst_seq wb_err async", 64'(wb_err), 64'd0);
    chk("rst_seq rs1_busy async", 64'(rs1_busy), 64'd0);
    @(posedge clk);
    #1;
    chk("rst_seq rf_wen at edge", 64'(rf_wen), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 3'b111;
    rs2 = 5'd7;
    #1;
    chk("rst_seq rr_ptr reset grant", 64'(req_ready), 64'(3'b001 << WB_ALU));
    chk("rst_seq rs2_busy x7 cleared", 64'(rs2_busy), 64'd0);
    @(negedge clk);
    drive_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
